// File: rtl/rvv_vrf_pkg.sv
// Shared types for the RVV backend vector register file bank.
package rvv_vrf_pkg;

    localparam int VRF_NUM_DEF = 32;
    localparam int VLEN_DEF    = 128;
    localparam int VRF_AW      = $clog2(VRF_NUM_DEF);
    localparam int VLENB       = VLEN_DEF / 8;

    typedef logic [VRF_AW-1:0]   vrf_addr_t;
    typedef logic [VLENB-1:0]    vrf_be_t;
    typedef logic [VLEN_DEF-1:0] vrf_data_t;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } vrf_clr_state_e;

endpackage

// File: rtl/rvv_backend_vrf_bank_if.sv
// Write/read/clear bus between the backend and the vector register file.
interface rvv_backend_vrf_bank_if #(
    parameter int NUM_VRF = 32,
    parameter int VLEN    = 128,
    parameter int NUM_WP  = 2,
    parameter int NUM_RP  = 4
);
    localparam int AW = $clog2(NUM_VRF);

    logic                                clr_req;
    logic                                clr_busy;
    logic                                wr_ready;
    logic [NUM_WP-1:0]                   wr_valid;
    logic [NUM_WP-1:0][AW-1:0]           wr_addr;
    logic [NUM_WP-1:0][VLEN/8-1:0]       wr_be;
    logic [NUM_WP-1:0][VLEN-1:0]         wr_data;
    logic [NUM_RP-1:0]                   rd_valid;
    logic [NUM_RP-1:0][AW-1:0]           rd_addr;
    logic [NUM_RP-1:0][VLEN-1:0]         rd_data;
    logic [NUM_RP-1:0]                   rd_dvalid;

    modport master (
        output clr_req, wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
        input  clr_busy, wr_ready, rd_data, rd_dvalid
    );

    modport slave (
        input  clr_req, wr_valid, wr_addr, wr_be, wr_data, rd_valid, rd_addr,
        output clr_busy, wr_ready, rd_data, rd_dvalid
    );

endinterface

// File: rtl/edff.sv
// Enable D flip-flop with asynchronous active-low reset to 0.
module edff (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic d,
    output logic q
);
    // hold unless enabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= 1'b0;
        else if (en) q <= d;
    end
endmodule

// File: rtl/rvv_backend_vrf_wmerge.sv
// Per-register write merge: prioritised byte writes plus clear-to-zero.
// nxt is the full post-edge value (unwritten bytes keep cur), ben marks
// which bytes actually change so the storage enables stay per byte.
module rvv_backend_vrf_wmerge #(
    parameter int NUM_VRF = 32,
    parameter int VLEN    = 128,
    parameter int NUM_WP  = 2,
    parameter int REG_IDX = 0
) (
    input  logic [NUM_WP-1:0]                           wr_acc,
    input  logic [NUM_WP-1:0][$clog2(NUM_VRF)-1:0]      wr_addr,
    input  logic [NUM_WP-1:0][VLEN/8-1:0]               wr_be,
    input  logic [NUM_WP-1:0][VLEN-1:0]                 wr_data,
    input  logic                                        clr,
    input  logic [VLEN-1:0]                             cur,
    output logic [VLEN-1:0]                             nxt,
    output logic [VLEN/8-1:0]                           ben
);
    localparam int AW = $clog2(NUM_VRF);

    // later ports overwrite earlier ones, so the highest port wins a byte
    always_comb begin
        nxt = cur;
        ben = '0;
        for (int p = 0; p < NUM_WP; p++) begin
            if (wr_acc[p] && wr_addr[p] == AW'(REG_IDX)) begin
                for (int b = 0; b < VLEN/8; b++) begin
                    if (wr_be[p][b]) begin
                        nxt[8*b +: 8] = wr_data[p][8*b +: 8];
                        ben[b]        = 1'b1;
                    end
                end
            end
        end
        if (clr) begin
            nxt = '0;
            ben = '1;
        end
    end
endmodule

// File: rtl/rvv_backend_vrf_bank.sv
// Vector register file bank: NUM_WP byte-enabled write ports, NUM_RP
// registered read ports with optional write-first bypass, and a clear
// sequencer zeroing one register per cycle.
module rvv_backend_vrf_bank
    import rvv_vrf_pkg::*;
#(
    parameter int NUM_VRF = 32,
    parameter int VLEN    = 128,
    parameter int NUM_WP  = 2,
    parameter int NUM_RP  = 4,
    parameter int BYPASS  = 1
) (
    input  logic                             clk,
    input  logic                             rst_n,
    rvv_backend_vrf_bank_if.slave            bus,
    output logic [NUM_VRF-1:0][VLEN-1:0]     vreg
);
    localparam int AW = $clog2(NUM_VRF);

    vrf_clr_state_e                  state_q, state_d;
    logic [AW-1:0]                   cnt_q, cnt_d;
    logic                            busy;
    logic [NUM_WP-1:0]               wr_acc;
    logic [NUM_VRF-1:0][VLEN-1:0]    nxt;
    logic [NUM_VRF-1:0][VLEN/8-1:0]  ben;
    logic [NUM_RP-1:0][VLEN-1:0]     rd_data_q;
    logic [NUM_RP-1:0]               rd_dvalid_q;

    // clear FSM state and register counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // clear FSM next state: clr_req is ignored once clearing
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.clr_req) begin
                    state_d = CLEAR;
                    cnt_d   = '0;
                end
            end
            CLEAR: begin
                cnt_d = cnt_q + AW'(1);
                if (cnt_q == AW'(NUM_VRF - 1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // clear FSM outputs, decoded from state only
    always_comb begin
        busy = (state_q == CLEAR);
    end

    assign bus.clr_busy = busy;
    assign bus.wr_ready = !busy;
    assign wr_acc       = bus.wr_valid & {NUM_WP{!busy}};

    for (genvar r = 0; r < NUM_VRF; r++) begin : g_reg
        rvv_backend_vrf_wmerge #(
            .NUM_VRF (NUM_VRF),
            .VLEN    (VLEN),
            .NUM_WP  (NUM_WP),
            .REG_IDX (r)
        ) u_wmerge (
            .wr_acc  (wr_acc),
            .wr_addr (bus.wr_addr),
            .wr_be   (bus.wr_be),
            .wr_data (bus.wr_data),
            .clr     (busy && cnt_q == AW'(r)),
            .cur     (vreg[r]),
            .nxt     (nxt[r]),
            .ben     (ben[r])
        );

        for (genvar i = 0; i < VLEN; i++) begin : g_bit
            edff u_ff (
                .clk   (clk),
                .rst_n (rst_n),
                .en    (ben[r][i/8]),
                .d     (nxt[r][i]),
                .q     (vreg[r][i])
            );
        end
    end

    // registered read ports; data holds when not requested
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q   <= '0;
            rd_dvalid_q <= '0;
        end else begin
            rd_dvalid_q <= bus.rd_valid;
            for (int k = 0; k < NUM_RP; k++) begin
                if (bus.rd_valid[k])
                    rd_data_q[k] <= (BYPASS != 0) ? nxt[bus.rd_addr[k]] : vreg[bus.rd_addr[k]];
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_dvalid = rd_dvalid_q;

`ifdef ASSERT_ON
    a_vreg_known: assert property (@(posedge clk) disable iff (!rst_n) !$isunknown(vreg));
    for (genvar p = 0; p < NUM_WP; p++) begin : g_wchk
        a_wr_known: assert property (@(posedge clk) disable iff (!rst_n)
            bus.wr_valid[p] |-> !$isunknown({bus.wr_addr[p], bus.wr_be[p]}));
        a_wr_hold: assert property (@(posedge clk) disable iff (!rst_n)
            (bus.wr_valid[p] && !bus.wr_ready) |=> bus.wr_valid[p])
            else $warning("wr_valid[%0d] dropped while wr_ready=0", p);
    end
`endif

endmodule

// File: doc/rvv_backend_vrf_bank.md
# rvv_backend_vrf_bank

Parametrised successor to the fixed 32×VLEN bit-enable vector register array. It stores `NUM_VRF` vector registers with `NUM_WP` byte-enabled write ports that resolve same-byte conflicts by priority, and `NUM_RP` registered read ports with optional write-to-read bypass. A clear sequencer zeroes the whole file one register per cycle on request. It sits between the ROB/retire write-back path and the dispatch operand-read path of the RVV backend.

## Interface
- `NUM_VRF`, 32: number of vector registers; power of two, ≥2.
- `VLEN`, 128: register width in bits; multiple of 8.
- `NUM_WP`, 2: write ports, ≥1.
- `NUM_RP`, 4: read ports, ≥1.
- `BYPASS`, 1: 1 gives write-first reads; 0 gives read-old.
- `clk` in 1: clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `clr_req` in 1: pulse that starts a full-file clear.
- `clr_busy` out 1: clear in progress.
- `wr_ready` out 1: equals `!clr_busy`.
- `wr_valid` in [NUM_WP]: write request, one bit per port.
- `wr_addr` in [NUM_WP][$clog2(NUM_VRF)]: destination register.
- `wr_be` in [NUM_WP][VLEN/8]: byte enables.
- `wr_data` in [NUM_WP][VLEN]: write data.
- `rd_valid` in [NUM_RP]: read request.
- `rd_addr` in [NUM_RP][$clog2(NUM_VRF)]: source register.
- `rd_data` out [NUM_RP][VLEN]: registered read data.
- `rd_dvalid` out [NUM_RP]: `rd_valid` delayed by one cycle.
- `vreg` out [NUM_VRF][VLEN]: live contents, for debug and trace.

## Operation
- Write acceptance:
  - A write is accepted when `wr_valid[p] && wr_ready`.
  - Writes presented while `wr_ready`=0 are dropped. The sender must hold them.
- Byte update: byte b of register r takes `wr_data[p][8b+7:8b]` from the highest-indexed accepted port p with `wr_addr[p]==r && wr_be[p][b]`. Bytes with no enabled port keep their value.
- Reads:
  - `rd_data[k]` loads on the edge where `rd_valid[k]`=1. Otherwise it holds its previous value.
  - BYPASS=1: the loaded value is the register content after this cycle's merged writes (write-first).
  - BYPASS=0: the loaded value is the pre-write content.
- Clear FSM states:
  - IDLE → CLEAR on `clr_req`=1. The counter is set to 0 and `clr_busy` rises on that edge.
  - In CLEAR, register[cnt] is zeroed each cycle and cnt increments.
  - When cnt==NUM_VRF-1, that register is zeroed and the FSM returns to IDLE on the same edge.
  - The clear takes exactly NUM_VRF cycles of `clr_busy`=1.
  - `clr_req` is ignored while in CLEAR.
  - Reads are allowed during CLEAR and return post-clear values under the same BYPASS rule: a cleared register reads 0 with BYPASS=1.
- Simultaneous events: `clr_req` arriving together with writes in IDLE → the writes are accepted that cycle and the clear starts the next cycle.
- Reset values: all registers 0, `rd_data` 0, `rd_dvalid` 0, FSM IDLE, `clr_busy` 0, `wr_ready` 1. Asserting reset mid-clear aborts the clear; the file is already 0.
- Assertions (ASSERT_ON):
  - No X on `vreg`.
  - No X on `wr_addr` or `wr_be` when the corresponding `wr_valid` is 1.
  - `wr_valid` must not drop while `wr_ready`=0 unless the sender retracts explicitly; this is a warning only.

## Timing
- Write-to-`vreg` latency: 1 cycle.
- Read latency: 1 cycle.
- Same-cycle write then read: governed by the BYPASS rule above.
- Clear: NUM_VRF cycles; `wr_ready` returns 1 in the cycle after the last clear edge.
- No combinational path from any input to any output except `wr_ready` (from FSM state only) and `vreg` (from state only).

## Structure
- Package `rvv_vrf_pkg`:
  - `VRF_AW = $clog2(NUM_VRF)` and `VLENB = VLEN/8`.
  - typedefs `vrf_addr_t`, `vrf_be_t`, `vrf_data_t`.
  - FSM enum `vrf_clr_state_e {IDLE, CLEAR}`.
- Sub-module `rvv_backend_vrf_wmerge`, one instance per register:
  - combinationally resolves the NUM_WP prioritised byte writes plus the clear-zero;
  - outputs next value and per-byte enable.
- Storage uses the existing `edff` cells, one per bit, with the enable driven per byte.

## Test plan
- Reset then read all registers → `rd_data`=0 and `rd_dvalid`=1 one cycle after each `rd_valid`.
- Port0 writes r3, be=0x000F, data=all 0xAA; port1 writes r3, be=0x0003, data=all 0x55 in the same cycle → r3 low 16 bits = 0x5555, bits 31:16 = 0xAAAA, rest 0.
- BYPASS=1: write r5=0x1234…, read r5 in the same cycle → `rd_data` = new value. With BYPASS=0 → old value (0).
- Fill r0–r31 with index pattern, pulse `clr_req` → `clr_busy` high for exactly 32 cycles, r0 zero after the first edge, writes dropped while `wr_ready`=0, all registers 0 at the end.
- `clr_req` together with a write to r31 → the write lands, then the clear zeroes r31 at cycle 32.
- Assert `rst_n` low at clear cycle 10 → `clr_busy`=0 immediately, file all 0, a new `clr_req` after reset restarts from r0.
